// File: rtl/effect_mailbox.sv
// Shared 32-word register mailbox between a strobe-driven effect engine and a host port.
// Define EFFECT_MAILBOX_RO_EN to make words 0..3 read-only from the effect engine side.
module effect_mailbox (
  input  logic        clk,
  input  logic        reset,
  input  logic        loc_ramclk,
  input  logic        loc_ramread,
  input  logic        loc_ramwrite,
  input  logic [4:0]  loc_ramaddress,
  input  logic [31:0] loc_writedata,
  output logic [31:0] loc_readdata,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_we,
  input  logic        host_re,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic        sample_req,
  output logic        out_valid,
  output logic [31:0] out_sample,
  output logic        host_wr_drop,
  output logic        loc_wr_err
);

  localparam logic [4:0] ADDR_INPUT        = 5'd3;
  localparam logic [4:0] ADDR_READ_FINISH  = 5'd4;
  localparam logic [4:0] ADDR_OUTPUT       = 5'd5;
  localparam logic [4:0] ADDR_READY_TO_GET = 5'd6;

  logic        ramclk_q;
  logic        cap_read;
  logic        cap_write;
  logic [4:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] regs [0:31];

  logic commit;
  logic loc_wr_allowed;
  logic loc_wr_en;
  logic loc_rd_en;
  logic host_conflict;
  logic host_wr_en;

  assign commit = loc_ramclk & ~ramclk_q;

`ifdef EFFECT_MAILBOX_RO_EN
  assign loc_wr_allowed = (cap_addr[4:2] != 3'b000);
`else
  assign loc_wr_allowed = 1'b1;
`endif

  assign loc_wr_en     = commit & cap_write & loc_wr_allowed;
  assign loc_rd_en     = commit & cap_read;
  assign host_conflict = host_we & loc_wr_en & (host_addr == cap_addr);
  assign host_wr_en    = host_we & ~host_conflict;

  // ramclk_q resets high so a strobe already high at reset release is not a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramclk_q  <= 1'b1;
      cap_read  <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      ramclk_q <= loc_ramclk;
      if (!loc_ramclk) begin
        cap_read  <= loc_ramread;
        cap_write <= loc_ramwrite;
        cap_addr  <= loc_ramaddress;
        cap_wdata <= loc_writedata;
      end
    end
  end

  // Later assignments win: host write, input-clears-flag, local write, read-sets-flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (host_wr_en) begin
        regs[host_addr] <= host_wdata;
        if (host_addr == ADDR_INPUT) begin
          regs[ADDR_READ_FINISH] <= 32'd0;
        end
      end
      if (loc_wr_en) begin
        regs[cap_addr] <= cap_wdata;
      end
      if (loc_rd_en && (cap_addr == ADDR_INPUT)) begin
        regs[ADDR_READ_FINISH] <= 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loc_readdata <= '0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      sample_req   <= 1'b0;
      out_valid    <= 1'b0;
      out_sample   <= '0;
      host_wr_drop <= 1'b0;
    end else begin
      if (loc_rd_en) begin
        loc_readdata <= regs[cap_addr];
      end
      if (host_re) begin
        host_rdata <= regs[host_addr];
      end
      host_rvalid  <= host_re;
      sample_req   <= loc_wr_en & (cap_addr == ADDR_READY_TO_GET);
      out_valid    <= loc_wr_en & (cap_addr == ADDR_OUTPUT);
      if (loc_wr_en && (cap_addr == ADDR_OUTPUT)) begin
        out_sample <= cap_wdata;
      end
      host_wr_drop <= host_conflict;
    end
  end

`ifdef EFFECT_MAILBOX_RO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loc_wr_err <= 1'b0;
    end else begin
      loc_wr_err <= commit & cap_write & ~loc_wr_allowed;
    end
  end
`else
  assign loc_wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_effect_mailbox.sv
// Self-checking bench for effect_mailbox: directed scenarios plus randomized traffic against
// a transaction-level model of the register file.
module tb_effect_mailbox;

  logic        clk;
  logic        reset;
  logic        loc_ramclk;
  logic        loc_ramread;
  logic        loc_ramwrite;
  logic [4:0]  loc_ramaddress;
  logic [31:0] loc_writedata;
  logic [31:0] loc_readdata;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_we;
  logic        host_re;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        sample_req;
  logic        out_valid;
  logic [31:0] out_sample;
  logic        host_wr_drop;
  logic        loc_wr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  logic [31:0] exp_loc;
  logic [31:0] exp_out_sample;
  logic [31:0] exp_hrdata;
  logic        exp_sreq;
  logic        exp_oval;
  logic        exp_drop;
  logic        exp_err;

  effect_mailbox dut (
    .clk            (clk),
    .reset          (reset),
    .loc_ramclk     (loc_ramclk),
    .loc_ramread    (loc_ramread),
    .loc_ramwrite   (loc_ramwrite),
    .loc_ramaddress (loc_ramaddress),
    .loc_writedata  (loc_writedata),
    .loc_readdata   (loc_readdata),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_we        (host_we),
    .host_re        (host_re),
    .host_rdata     (host_rdata),
    .host_rvalid    (host_rvalid),
    .sample_req     (sample_req),
    .out_valid      (out_valid),
    .out_sample     (out_sample),
    .host_wr_drop   (host_wr_drop),
    .loc_wr_err     (loc_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ro_blocked(input logic [4:0] a);
`ifdef EFFECT_MAILBOX_RO_EN
    return (a < 5'd4);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp_loc = '0;
    exp_out_sample = '0;
    exp_hrdata = '0;
  endtask

  // One engine access: capture cycle, then the strobe rises with garbage on the fields,
  // optionally alongside a host operation. Returns right after the commit edge.
  task automatic local_access(input logic rd, input logic wr, input logic [4:0] a,
                              input logic [31:0] d, input logic hwe, input logic hre,
                              input logic [4:0] ha, input logic [31:0] hd);
    logic [31:0] old;
    bit blocked;
    bit conflict;
    loc_ramclk = 1'b0;
    loc_ramread = rd;
    loc_ramwrite = wr;
    loc_ramaddress = a;
    loc_writedata = d;
    host_we = 1'b0;
    host_re = 1'b0;
    tick();
    loc_ramclk = 1'b1;
    loc_ramread = 1'($urandom);
    loc_ramwrite = 1'($urandom);
    loc_ramaddress = 5'($urandom);
    loc_writedata = $urandom;
    host_we = hwe;
    host_re = hre;
    host_addr = ha;
    host_wdata = hd;
    tick();
    host_we = 1'b0;
    host_re = 1'b0;
    old = mdl[a];
    blocked = ro_blocked(a);
    conflict = hwe && wr && !blocked && (ha == a);
    if (hre) exp_hrdata = mdl[ha];
    if (hwe && !conflict) begin
      mdl[ha] = hd;
      if (ha == 5'd3) mdl[4] = 32'd0;
    end
    if (wr && !blocked) mdl[a] = d;
    if (rd) begin
      exp_loc = old;
      if (a == 5'd3) mdl[4] = 32'd1;
    end
    exp_sreq = wr && !blocked && (a == 5'd6);
    exp_oval = wr && !blocked && (a == 5'd5);
    if (exp_oval) exp_out_sample = d;
    exp_drop = conflict;
    exp_err = wr && blocked;
  endtask

  task automatic release_strobe();
    loc_ramclk = 1'b0;
    loc_ramread = 1'b0;
    loc_ramwrite = 1'b0;
    tick();
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    tick();
    host_we = 1'b0;
    mdl[a] = d;
    if (a == 5'd3) mdl[4] = 32'd0;
  endtask

  task automatic host_read(input logic [4:0] a);
    host_re = 1'b1;
    host_addr = a;
    tick();
    host_re = 1'b0;
    exp_hrdata = mdl[a];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    loc_ramclk = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({loc_readdata, host_rdata, out_sample} !== 96'd0 ||
        {host_rvalid, sample_req, out_valid, host_wr_drop, loc_wr_err} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: rd=%h hr=%h os=%h pulses=%b expected all zero",
               loc_readdata, host_rdata, out_sample,
               {host_rvalid, sample_req, out_valid, host_wr_drop, loc_wr_err});
    end
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    loc_ramwrite = 1'b0;
    repeat (2) tick();
    checks++;
    if ({sample_req, out_valid, host_wr_drop, loc_wr_err} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_release_pulses: got %b expected 0000",
               {sample_req, out_valid, host_wr_drop, loc_wr_err});
    end
    for (int i = 0; i < 32; i++) begin
      host_read(5'(i));
      checks++;
      if (host_rdata !== 32'd0 || host_rvalid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_reg[%0d]: got %h valid %b expected 0 valid 1", i, host_rdata, host_rvalid);
      end
    end
    tick();
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rvalid_one_cycle: got %b expected 0", host_rvalid);
    end
  endtask

  task automatic test_sample_req();
    local_access(1'b0, 1'b1, 5'd6, 32'd1100, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (sample_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sample_req_pulse: got %b expected 1", sample_req);
    end
    // Strobe stays high: there must be no second commit.
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sample_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sample_req_held_high[%0d]: got %b expected 0", i, sample_req);
      end
    end
    release_strobe();
    host_read(5'd6);
    checks++;
    if (host_rdata !== 32'd1100) begin
      errors++;
      $display("[TB] FAIL reg6_value: got %0d expected 1100", host_rdata);
    end
  endtask

  task automatic test_read_finish();
    local_access(1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    release_strobe();
    host_write(5'd3, 32'h1234);
    host_read(5'd4);
    checks++;
    if (host_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL read_finish_cleared: got %h expected 0", host_rdata);
    end
    local_access(1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (loc_readdata !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL input_readback: got %h expected 00001234", loc_readdata);
    end
    release_strobe();
    host_read(5'd4);
    checks++;
    if (host_rdata !== 32'd1) begin
      errors++;
      $display("[TB] FAIL read_finish_set: got %h expected 1", host_rdata);
    end
  endtask

  task automatic test_output();
    logic [31:0] d;
    d = $urandom;
    local_access(1'b0, 1'b1, 5'd5, d, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (out_valid !== 1'b1 || out_sample !== d) begin
      errors++;
      $display("[TB] FAIL output_write: valid %b sample %h expected 1 %h", out_valid, out_sample, d);
    end
    release_strobe();
    local_access(1'b0, 1'b1, 5'd9, ~d, 1'b0, 1'b0, 5'd0, 32'd0);
    release_strobe();
    checks++;
    if (out_valid !== 1'b0 || out_sample !== d) begin
      errors++;
      $display("[TB] FAIL output_hold: valid %b sample %h expected 0 %h", out_valid, out_sample, d);
    end
  endtask

  task automatic test_conflicts();
    logic [31:0] old12;
    local_access(1'b0, 1'b1, 5'd10, 32'h5555, 1'b1, 1'b0, 5'd10, 32'hAAAA);
    checks++;
    if (host_wr_drop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL host_wr_drop_pulse: got %b expected 1", host_wr_drop);
    end
    release_strobe();
    checks++;
    if (host_wr_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL host_wr_drop_clear: got %b expected 0", host_wr_drop);
    end
    host_read(5'd10);
    checks++;
    if (host_rdata !== 32'h5555) begin
      errors++;
      $display("[TB] FAIL local_wins: got %h expected 00005555", host_rdata);
    end
    host_write(5'd12, 32'hCAFE0012);
    old12 = 32'hCAFE0012;
    local_access(1'b0, 1'b1, 5'd12, 32'h0BAD0012, 1'b0, 1'b1, 5'd12, 32'd0);
    checks++;
    if (host_rdata !== old12 || host_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL host_read_prewrite: got %h valid %b expected %h valid 1", host_rdata, host_rvalid, old12);
    end
    release_strobe();
    host_read(5'd12);
    checks++;
    if (host_rdata !== 32'h0BAD0012) begin
      errors++;
      $display("[TB] FAIL host_read_postwrite: got %h expected 0bad0012", host_rdata);
    end
    host_write(5'd15, 32'h1111_2222);
    local_access(1'b1, 1'b1, 5'd15, 32'h3333_4444, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (loc_readdata !== 32'h1111_2222) begin
      errors++;
      $display("[TB] FAIL rw_same_old: got %h expected 11112222", loc_readdata);
    end
    release_strobe();
    host_read(5'd15);
    checks++;
    if (host_rdata !== 32'h3333_4444) begin
      errors++;
      $display("[TB] FAIL rw_same_new: got %h expected 33334444", host_rdata);
    end
  endtask

  task automatic test_ro_guard();
    logic [31:0] reg1_before;
    reg1_before = mdl[1];
    local_access(1'b0, 1'b1, 5'd1, 32'hBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
`ifdef EFFECT_MAILBOX_RO_EN
    if (loc_wr_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ro_err_pulse: got %b expected 1", loc_wr_err);
    end
`else
    if (loc_wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ro_err_tied: got %b expected 0", loc_wr_err);
    end
`endif
    release_strobe();
    checks++;
    if (loc_wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ro_err_clear: got %b expected 0", loc_wr_err);
    end
    host_read(5'd1);
    checks++;
`ifdef EFFECT_MAILBOX_RO_EN
    if (host_rdata !== reg1_before) begin
      errors++;
      $display("[TB] FAIL ro_reg1_kept: got %h expected %h", host_rdata, reg1_before);
    end
`else
    if (host_rdata !== 32'hBEEF) begin
      errors++;
      $display("[TB] FAIL reg1_written: got %h expected 0000beef", host_rdata);
    end
`endif
    host_write(5'd2, 32'h2222);
    host_read(5'd2);
    checks++;
    if (host_rdata !== 32'h2222) begin
      errors++;
      $display("[TB] FAIL host_write_low: got %h expected 00002222", host_rdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(2, 0))
        0: host_write(5'($urandom), $urandom);
        1: begin
          host_read(5'($urandom));
          checks++;
          if (host_rdata !== exp_hrdata) begin
            errors++;
            $display("[TB] FAIL rand_host_read[%0d]: got %h expected %h", n, host_rdata, exp_hrdata);
          end
        end
        default: begin
          local_access(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                       1'b0, 1'b0, 5'd0, 32'd0);
          checks++;
          if (loc_readdata !== exp_loc || sample_req !== exp_sreq || out_valid !== exp_oval ||
              out_sample !== exp_out_sample || host_wr_drop !== 1'b0 || loc_wr_err !== exp_err) begin
            errors++;
            $display("[TB] FAIL rand_local[%0d]: rd=%h sr=%b ov=%b os=%h dr=%b er=%b expected rd=%h sr=%b ov=%b os=%h dr=0 er=%b",
                     n, loc_readdata, sample_req, out_valid, out_sample, host_wr_drop, loc_wr_err,
                     exp_loc, exp_sreq, exp_oval, exp_out_sample, exp_err);
          end
          release_strobe();
        end
      endcase
    end
    for (int i = 0; i < 32; i++) begin
      host_read(5'(i));
      checks++;
      if (host_rdata !== exp_hrdata) begin
        errors++;
        $display("[TB] FAIL rand_final_reg[%0d]: got %h expected %h", i, host_rdata, exp_hrdata);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    loc_ramclk = 1'b0;
    loc_ramread = 1'b1;
    loc_ramwrite = 1'b1;
    loc_ramaddress = 5'd20;
    loc_writedata = 32'hDEAD_0020;
    tick();
    loc_ramclk = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({loc_readdata, host_rdata, out_sample} !== 96'd0 ||
        {host_rvalid, sample_req, out_valid, host_wr_drop, loc_wr_err} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: rd=%h hr=%h os=%h pulses=%b expected all zero",
               loc_readdata, host_rdata, out_sample,
               {host_rvalid, sample_req, out_valid, host_wr_drop, loc_wr_err});
    end
    release_strobe();
    loc_ramclk = 1'b1;
    tick();
    release_strobe();
    host_read(5'd20);
    checks++;
    if (host_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_reg20: got %h expected 0", host_rdata);
    end
    host_read(5'd10);
    checks++;
    if (host_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_reg10: got %h expected 0", host_rdata);
    end
  endtask

  initial begin
    loc_ramclk = 1'b1;
    loc_ramread = 1'b0;
    loc_ramwrite = 1'b0;
    loc_ramaddress = '0;
    loc_writedata = '0;
    host_addr = '0;
    host_wdata = '0;
    host_we = 1'b0;
    host_re = 1'b0;
    exp_sreq = 1'b0;
    exp_oval = 1'b0;
    exp_drop = 1'b0;
    exp_err = 1'b0;
    model_reset();
    test_reset();
    test_sample_req();
    test_read_finish();
    test_output();
    test_conflicts();
    test_ro_guard();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/effect_mailbox.md
EFFECT_MAILBOX -- requirements
Module: effect_mailbox

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port loc_ramclk  in  1  strobe from the effect engine; its rising edge commits an access.
REQ-004 SHALL have port loc_ramread  in  1  read request qualifier.
REQ-005 SHALL have port loc_ramwrite  in  1  write request qualifier.
REQ-006 SHALL have port loc_ramaddress  in  5  word address, 0..31.
REQ-007 SHALL have port loc_writedata  in  32  write data from the effect engine.
REQ-008 SHALL have port loc_readdata  out  32  read data returned to the effect engine.
REQ-009 SHALL have ports host_addr in 5, host_wdata in 32, host_we in 1, host_re in 1: host-side single-cycle access.
REQ-010 SHALL have ports host_rdata out 32, host_rvalid out 1: host read return.
REQ-011 SHALL have ports sample_req out 1, out_valid out 1, out_sample out 32, host_wr_drop out 1, loc_wr_err out 1.

Function
REQ-012 SHALL hold 32 x 32-bit registers; map: 0 SE, 1 DISTORTION_GAIN, 2 DISTORTION_BOOST, 3 INPUT, 4 READ_FINISH, 5 OUTPUT, 6 READY_TO_GET, 7..31 scratch.
REQ-013 SHALL capture loc_ramread, loc_ramwrite, loc_ramaddress, loc_writedata every cycle in which loc_ramclk is 0; the capture holds while loc_ramclk is 1.
REQ-014 SHALL detect a commit when loc_ramclk is 1 and its registered copy ramclk_q is 0; only captured fields are used, never the inputs in the commit cycle.
REQ-015 Commit with captured write=1 SHALL write the register in the same clock edge; captured read=1 SHALL load loc_readdata with that register's value on the same edge, and loc_readdata SHALL hold until the next read commit.
REQ-016 Captured read=1 and write=1 together SHALL return the old value on loc_readdata and then write the new value.
REQ-017 A committed local write to address 6 SHALL pulse sample_req high for exactly one cycle, the cycle after commit.
REQ-018 A committed local write to address 5 SHALL pulse out_valid for one cycle and load out_sample with the written data; out_sample SHALL hold until the next such write.
REQ-019 A host write to address 3 SHALL set register 4 to 0; a committed local read of address 3 SHALL set register 4 to 1 (read-finish flag).
REQ-020 host_we SHALL write host_wdata to host_addr on the same edge; host_re SHALL drive host_rdata next cycle with host_rvalid high for that one cycle.
REQ-021 Host write and local write commit to the same address in one cycle: local SHALL win, host data dropped, host_wr_drop pulses one cycle.
REQ-022 Host read of an address written in the same cycle SHALL return the pre-write value.
REQ-023 loc_ramclk held high SHALL produce no further commits; one commit per 0-to-1 transition.

Reset
REQ-024 reset high SHALL asynchronously clear all 32 registers, loc_readdata, host_rdata, out_sample and all captured fields to 0, and all pulse outputs to 0.
REQ-025 reset SHALL set ramclk_q to 1 so a loc_ramclk already high at reset release does not commit.
REQ-026 reset asserted mid-access SHALL abandon that access; no write lands after release without a fresh 0-to-1 strobe.

Configuration
REQ-027 With macro EFFECT_MAILBOX_RO_EN defined, local write commits to addresses 0..3 SHALL be ignored and pulse loc_wr_err one cycle; host writes unaffected.
REQ-028 Without EFFECT_MAILBOX_RO_EN, local writes SHALL land at any address and loc_wr_err SHALL be tied 0.

Verification
REQ-029 Local sequence ramclk=0/write=1/addr=6/data=1100 then ramclk=1/write=0 -> reg6=1100, sample_req one-cycle pulse the next cycle.
REQ-030 Host writes 0x1234 to addr 3, then local read of addr 3 -> loc_readdata=0x1234, reg4 goes 0 then 1.
REQ-031 Same-cycle host write 0xAAAA and local commit 0x5555 to addr 10 -> reg10=0x5555, host_wr_drop pulses once.
REQ-032 Local write 0xBEEF to addr 1: with EFFECT_MAILBOX_RO_EN -> reg1 unchanged, loc_wr_err pulses; without -> reg1=0xBEEF.
REQ-033 Assert reset while loc_ramclk=1 and captured write pending, release with loc_ramclk still 1 -> no register changes, all outputs 0.
